ic_line_fill: RTL and testbench
===============================

Name: ic_line_fill

Overview:
- Miss-side initiator for the instruction cache.
- When the cache reports a miss and permits replacement, fetches the whole line from backing instruction memory one word per request/ack handshake. Order is critical-word-first, wrapping within the line.
- Streams each returned word into the cache data array and forwards the critical word early so fetch can restart.
- Sits between the instruction cache and the backing instruction memory. The backing memory is the responder on this interface.

Parameters:
- BLOCK_WORDS, 4, words per cache line; power of two, 2..16.
- ADDR_W, 32, byte-address width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- miss_i  in  1  cache miss request; level, sampled only in IDLE.
- miss_addr_i  in  ADDR_W  faulting fetch byte address; bits [1:0] ignored.
- repl_permit_i  in  1  cache allows the victim line to be overwritten.
- flush_i  in  1  abort the current fill (branch redirect / fence).
- mem_req_o  out  1  word read request to backing memory.
- mem_addr_o  out  ADDR_W  word-aligned request address.
- mem_ack_i  in  1  backing memory accepts the request and returns data this cycle.
- mem_rdata_i  in  32  read data; valid when mem_req_o && mem_ack_i.
- fill_we_o  out  1  write one word into the cache line.
- fill_idx_o  out  log2(BLOCK_WORDS)  word index within the line.
- fill_data_o  out  32  word to write.
- fill_base_o  out  ADDR_W  line-aligned base address (tag source), stable while busy_o.
- crit_valid_o  out  1  one-cycle pulse: critical word available.
- crit_data_o  out  32  critical word.
- fill_done_o  out  1  one-cycle pulse: line complete and valid.
- busy_o  out  1  high whenever state != IDLE.

Behaviour:
- Reset (reset_i high at a clock edge, in any state including mid-fill):
  - State goes to IDLE and all outputs go to 0.
  - Word counter and captured addresses clear.
  - An in-flight handshake is dropped. Backing memory must tolerate request withdrawal on reset.
- States: IDLE, WAIT_PERMIT, REQ, WRITE_LAST, DONE.
- IDLE:
  - On miss_i, capture base = miss_addr_i with the low log2(BLOCK_WORDS)+2 bits zeroed, and crit_idx = miss_addr_i word-index bits.
  - Go to REQ if repl_permit_i is also high, otherwise WAIT_PERMIT.
- WAIT_PERMIT: hold until repl_permit_i = 1, then go to REQ. flush_i here returns to IDLE.
- REQ:
  - mem_req_o = 1.
  - mem_addr_o = base + 4*((crit_idx + cnt) mod BLOCK_WORDS); the index wraps modulo BLOCK_WORDS.
  - mem_addr_o is held stable until mem_ack_i is sampled high.
  - On ack: register mem_rdata_i and the index, and increment cnt.
  - If more words remain, the next request follows back-to-back the following cycle with the new address.
  - After the last ack, go to WRITE_LAST.
- Cache write path:
  - fill_we_o/fill_idx_o/fill_data_o are registered and assert exactly one cycle after each ack.
  - Each word is written exactly once.
- Critical word:
  - crit_valid_o/crit_data_o pulse in the same cycle as the first fill_we_o (idx = crit_idx).
- WRITE_LAST: the cycle carrying the final fill_we_o; then go to DONE.
- DONE: fill_done_o = 1 for one cycle, then IDLE.
  - miss_i is not sampled in DONE. Earliest new capture is the cycle after DONE.
- Minimum latency (ack tied high), from miss capture to fill_done_o: BLOCK_WORDS + 2 cycles.
- flush_i:
  - In REQ with no ack the same cycle: drop mem_req_o next cycle and return to IDLE.
  - With a same-cycle ack: the word is still written (fill_we_o next cycle), then return to IDLE.
  - An aborted fill never pulses fill_done_o. crit_valid_o may already have fired.
  - flush_i outranks miss_i in IDLE; both ignored when reset_i is high.
- mem_ack_i while mem_req_o = 0 is ignored.

Decomposition:
- Package ic_fill_pkg holds:
  - the state enum (fill_state_t);
  - BLOCK_WORDS-derived localparams (IDX_W, OFFSET_W);
  - a function computing the wrapped word index.
- No sub-module; counter and datapath are inline in one module of roughly 150–250 lines.

Test Plan:
1. Critical-word order: BLOCK_WORDS=4, ack tied high, repl_permit_i=1, miss_addr_i=0x0000_1008.
   -> mem_addr_o sequence 0x1008, 0x100C, 0x1000, 0x1004 on consecutive cycles; fill_idx_o 2,3,0,1; fill_base_o=0x1000; crit_valid_o with the idx-2 write; fill_done_o 6 cycles after capture.
2. Permit stall: miss at 0x2000, repl_permit_i low for 5 cycles.
   -> mem_req_o stays 0 and busy_o=1 throughout; first request to 0x2000 the cycle after permit rises.
3. Slow memory: ack asserted every 3rd cycle, miss 0x300C.
   -> mem_addr_o held at 0x300C until the first ack, then 0x3000, 0x3004, 0x3008; exactly 4 fill_we_o pulses, each one cycle after its ack.
4. Flush mid-fill: flush_i after the 2nd ack, no ack in the flush cycle.
   -> mem_req_o drops next cycle; no fill_done_o; busy_o=0 one cycle later.
5. Flush with same-cycle ack: flush_i and mem_ack_i together on word 3.
   -> that word is written (fill_we_o next cycle); then IDLE; no fill_done_o.
6. Reset mid-REQ: reset_i pulsed during REQ.
   -> all outputs 0 next cycle; a new miss at 0x4004 fills correctly with order 0x4004, 0x4008, 0x400C, 0x4000.

Source files
------------

// File: rtl/ic_fill_pkg.sv
// Shared definitions for the instruction-cache line-fill engine.
// Holds the cache line geometry, the fill FSM state type and the helper
// that turns (critical word, words already fetched) into a wrapped word index.
package ic_fill_pkg;

    // Line geometry: words per cache line (power of two, 2..16), the width of
    // a word index within the line, and the byte-offset width of a line.
    localparam int BLOCK_WORDS = 4;
    localparam int IDX_W       = $clog2(BLOCK_WORDS);
    localparam int OFFSET_W    = IDX_W + 2;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PERMIT,
        REQ,
        WRITE_LAST,
        DONE
    } fill_state_t;

    // Critical-word-first order: the n-th word fetched is (crit + n) within
    // the line. Because BLOCK_WORDS is a power of two, dropping the carry out
    // of an IDX_W-bit add is exactly the modulo-BLOCK_WORDS wrap.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] crit_idx,
                                                  input logic [IDX_W-1:0] cnt);
        return crit_idx + cnt;
    endfunction

endpackage

// File: rtl/ic_line_fill.sv
// Instruction-cache miss-side line fill engine.
// On a permitted miss, fetches the whole line from backing memory one word
// per req/ack handshake, critical word first and wrapping within the line,
// writes each returned word into the cache data array one cycle after its ack
// and pulses the critical word out early so fetch can restart.
//
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   miss_i, miss_addr_i   miss request (level, sampled in IDLE) and byte address
//   repl_permit_i         victim line may be overwritten
//   flush_i               abort the current fill
//   mem_req_o/addr_o      word read request to backing memory
//   mem_ack_i/rdata_i     accept + data from backing memory (same cycle)
//   fill_we/idx/data_o    registered write port into the cache line
//   fill_base_o           line-aligned base address (tag source)
//   crit_valid/data_o     one-cycle critical-word pulse
//   fill_done_o           one-cycle pulse when the line is complete
//   busy_o                engine is not idle
module ic_line_fill
    import ic_fill_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              miss_i,
    input  logic [ADDR_W-1:0] miss_addr_i,
    input  logic              repl_permit_i,
    input  logic              flush_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              fill_we_o,
    output logic [IDX_W-1:0]  fill_idx_o,
    output logic [31:0]       fill_data_o,
    output logic [ADDR_W-1:0] fill_base_o,
    output logic              crit_valid_o,
    output logic [31:0]       crit_data_o,
    output logic              fill_done_o,
    output logic              busy_o
);

    // Clears the in-line byte offset; the low two bits of the miss address
    // are dropped here along with the word index.
    localparam logic [ADDR_W-1:0] LINE_MASK =
        ~((ADDR_W'(1) << OFFSET_W) - ADDR_W'(1));

    fill_state_t       state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [IDX_W-1:0]  crit_idx_q, crit_idx_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              fill_we_q, fill_we_d;
    logic [IDX_W-1:0]  fill_idx_q, fill_idx_d;
    logic [31:0]       fill_data_q, fill_data_d;
    logic              crit_valid_q, crit_valid_d;
    logic [31:0]       crit_data_q, crit_data_d;

    logic [IDX_W-1:0]  cur_idx;
    logic              last_word;

    assign cur_idx   = wrap_idx(crit_idx_q, cnt_q);
    assign last_word = (cnt_q == IDX_W'(BLOCK_WORDS - 1));

    // Next-state and output logic. Only REQ drives the memory interface, so
    // an ack outside REQ never reaches the write path. A flush in REQ wins
    // over the normal progression but a same-cycle ack still lands its word,
    // since the write path is registered from the ack regardless of flush.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        crit_idx_d   = crit_idx_q;
        cnt_d        = cnt_q;
        fill_we_d    = 1'b0;
        fill_idx_d   = fill_idx_q;
        fill_data_d  = fill_data_q;
        crit_valid_d = 1'b0;
        crit_data_d  = crit_data_q;

        mem_req_o    = 1'b0;
        mem_addr_o   = '0;
        fill_done_o  = 1'b0;
        busy_o       = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (!flush_i && miss_i) begin
                    base_d     = miss_addr_i & LINE_MASK;
                    crit_idx_d = miss_addr_i[OFFSET_W-1:2];
                    cnt_d      = '0;
                    state_d    = repl_permit_i ? REQ : WAIT_PERMIT;
                end
            end
            WAIT_PERMIT: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (repl_permit_i) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = base_q | ADDR_W'({cur_idx, 2'b00});
                if (mem_ack_i) begin
                    fill_we_d   = 1'b1;
                    fill_idx_d  = cur_idx;
                    fill_data_d = mem_rdata_i;
                    if (cnt_q == '0) begin
                        crit_valid_d = 1'b1;
                        crit_data_d  = mem_rdata_i;
                    end
                    cnt_d = cnt_q + IDX_W'(1);
                    if (last_word) begin
                        state_d = WRITE_LAST;
                    end
                end
                if (flush_i) begin
                    state_d = IDLE;
                end
            end
            WRITE_LAST: begin
                state_d = flush_i ? IDLE : DONE;
            end
            DONE: begin
                fill_done_o = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset clears everything, including any
    // handshake in flight; the memory simply sees its request withdrawn.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            base_q       <= '0;
            crit_idx_q   <= '0;
            cnt_q        <= '0;
            fill_we_q    <= 1'b0;
            fill_idx_q   <= '0;
            fill_data_q  <= '0;
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            crit_idx_q   <= crit_idx_d;
            cnt_q        <= cnt_d;
            fill_we_q    <= fill_we_d;
            fill_idx_q   <= fill_idx_d;
            fill_data_q  <= fill_data_d;
            crit_valid_q <= crit_valid_d;
            crit_data_q  <= crit_data_d;
        end
    end

    assign fill_we_o    = fill_we_q;
    assign fill_idx_o   = fill_idx_q;
    assign fill_data_o  = fill_data_q;
    assign fill_base_o  = base_q;
    assign crit_valid_o = crit_valid_q;
    assign crit_data_o  = crit_data_q;

endmodule

// File: tb/tb_ic_line_fill.sv
// Self-checking bench for ic_line_fill: a table of fill scenarios plus a few
// hand-written sequences (reset mid-fill, flush vs miss in IDLE) and a batch
// of randomized fills, all judged by a transaction-level model of the line
// fill (word order, one write per ack, done after the last write).
module tb_ic_line_fill;
    import ic_fill_pkg::*;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset_i;
    logic              miss_i;
    logic [ADDR_W-1:0] miss_addr_i;
    logic              repl_permit_i;
    logic              flush_i;
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_ack_i;
    logic [31:0]       mem_rdata_i;
    logic              fill_we_o;
    logic [IDX_W-1:0]  fill_idx_o;
    logic [31:0]       fill_data_o;
    logic [ADDR_W-1:0] fill_base_o;
    logic              crit_valid_o;
    logic [31:0]       crit_data_o;
    logic              fill_done_o;
    logic              busy_o;

    int checks = 0;
    int errors = 0;

    // Free-running clock, 10 time-unit period
    always #5 clk = ~clk;

    ic_line_fill #(.ADDR_W(ADDR_W)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .miss_i       (miss_i),
        .miss_addr_i  (miss_addr_i),
        .repl_permit_i(repl_permit_i),
        .flush_i      (flush_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i),
        .fill_we_o    (fill_we_o),
        .fill_idx_o   (fill_idx_o),
        .fill_data_o  (fill_data_o),
        .fill_base_o  (fill_base_o),
        .crit_valid_o (crit_valid_o),
        .crit_data_o  (crit_data_o),
        .fill_done_o  (fill_done_o),
        .busy_o       (busy_o)
    );

    // One fill scenario: inputs plus the constants expected for it.
    // ackPeriod 0 means a random ack each cycle; flushAfter < 0 means no flush;
    // expDone 0 means the done cycle is not pinned to a constant.
    typedef struct {
        logic [31:0] addr;
        int          permitDelay;
        int          ackPeriod;
        int          flushAfter;
        bit          flushWithAck;
        logic [31:0] expBase;
        logic [31:0] expFirst;
        int          expDone;
    } vec_t;

    vec_t vecs[7];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idleInputs();
        reset_i       = 1'b0;
        miss_i        = 1'b0;
        miss_addr_i   = '0;
        repl_permit_i = 1'b0;
        flush_i       = 1'b0;
        mem_ack_i     = 1'b0;
        mem_rdata_i   = '0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".mem_req"},    32'(mem_req_o),    32'd0);
        checkOutput({tag, ".mem_addr"},   mem_addr_o,        32'd0);
        checkOutput({tag, ".fill_we"},    32'(fill_we_o),    32'd0);
        checkOutput({tag, ".fill_idx"},   32'(fill_idx_o),   32'd0);
        checkOutput({tag, ".fill_data"},  fill_data_o,       32'd0);
        checkOutput({tag, ".fill_base"},  fill_base_o,       32'd0);
        checkOutput({tag, ".crit_valid"}, 32'(crit_valid_o), 32'd0);
        checkOutput({tag, ".crit_data"},  crit_data_o,       32'd0);
        checkOutput({tag, ".fill_done"},  32'(fill_done_o),  32'd0);
        checkOutput({tag, ".busy"},       32'(busy_o),       32'd0);
    endtask

    // Drives one complete fill and checks every cycle against the model:
    // the k-th accepted request must address base + 4*((crit+k) mod BW), each
    // accepted word appears on the write port exactly one cycle later, the
    // critical word is the first one, and done follows the last write.
    task automatic applyStimulus(input vec_t v);
        logic [31:0] base;
        int          crit;
        int          acks        = 0;
        bit          granted     = 0;
        bit          grantedNext = 0;
        bit          aborted     = 0;
        bit          abortedNext = 0;
        int          abortCycles = 0;
        bit          pendW = 0, pendCrit = 0, pendLast = 0;
        int          pendIdx = 0;
        logic [31:0] pendData = '0;
        bit          lastWritePrev = 0;
        bit          donePrev = 0;
        bit          doneSeen = 0;
        bit          finished = 0;
        bit          expReq, expBusy, expDone, ack, flush;

        base = v.addr - (v.addr % (4 * BLOCK_WORDS));
        crit = int'((v.addr / 4) % BLOCK_WORDS);

        @(negedge clk);
        miss_i        = 1'b1;
        miss_addr_i   = v.addr;
        repl_permit_i = (v.permitDelay == 0);
        flush_i       = 1'b0;
        mem_ack_i     = 1'b0;
        grantedNext   = (v.permitDelay == 0);

        for (int c = 1; c < 300 && !finished; c++) begin
            @(negedge clk);
            granted = grantedNext;
            aborted = abortedNext;
            expReq  = granted && !aborted && (acks < BLOCK_WORDS);
            expDone = lastWritePrev;
            expBusy = !aborted && !donePrev;

            checkOutput("busy",      32'(busy_o),      32'(expBusy));
            checkOutput("mem_req",   32'(mem_req_o),   32'(expReq));
            checkOutput("fill_done", 32'(fill_done_o), 32'(expDone));
            checkOutput("fill_we",   32'(fill_we_o),   32'(pendW));
            checkOutput("crit_valid", 32'(crit_valid_o), 32'(pendW && pendCrit));
            if (expBusy) checkOutput("fill_base", fill_base_o, base);
            if (expReq) begin
                checkOutput("mem_addr", mem_addr_o, base + 32'(4 * ((crit + acks) % BLOCK_WORDS)));
                if (acks == 0) begin
                    checkOutput("first_addr", mem_addr_o, v.expFirst);
                    checkOutput("table_base", fill_base_o, v.expBase);
                end
            end
            if (pendW) begin
                checkOutput("fill_idx",  32'(fill_idx_o), 32'(pendIdx));
                checkOutput("fill_data", fill_data_o,     pendData);
                if (pendCrit) checkOutput("crit_data", crit_data_o, pendData);
            end
            if (expDone) begin
                doneSeen = 1;
                if (v.expDone > 0) checkOutput("done_cycle", 32'(c), 32'(v.expDone));
            end

            if (donePrev) finished = 1;
            if (aborted) begin
                abortCycles++;
                if (abortCycles >= 3) finished = 1;
            end
            donePrev      = expDone;
            lastWritePrev = pendW && pendLast && !aborted;

            // Inputs for this cycle, sampled at the next rising edge
            miss_i        = 1'b0;
            repl_permit_i = (c >= v.permitDelay);
            grantedNext   = granted || repl_permit_i;
            if (v.ackPeriod == 0) ack = ($urandom_range(0, 1) == 1);
            else                  ack = ((c % v.ackPeriod) == 0);
            flush = expReq && (v.flushAfter >= 0) && (acks == v.flushAfter);
            if (flush) ack = v.flushWithAck;
            flush_i     = flush;
            mem_ack_i   = ack;
            mem_rdata_i = $urandom;

            pendW = expReq && ack;
            if (pendW) begin
                pendIdx  = (crit + acks) % BLOCK_WORDS;
                pendData = mem_rdata_i;
                pendCrit = (acks == 0);
                pendLast = (acks == BLOCK_WORDS - 1);
                acks++;
            end
            if (flush) abortedNext = 1;
        end

        if (!finished) begin
            checks++;
            errors++;
            $display("[TB] FAIL fill_timeout: got no completion expected completion addr=0x%08h", v.addr);
        end
        if (v.flushAfter < 0) checkOutput("done_seen", 32'(doneSeen), 32'd1);
        else                  checkOutput("no_done_after_flush", 32'(doneSeen), 32'd0);
        idleInputs();
    endtask

    initial begin
        vec_t rv;
        //           addr          pd ap  fa fwa  expBase       expFirst      done
        vecs[0] = '{32'h0000_1008, 0, 1, -1, 0, 32'h0000_1000, 32'h0000_1008, 6};
        vecs[1] = '{32'h0000_2000, 5, 1, -1, 0, 32'h0000_2000, 32'h0000_2000, 11};
        vecs[2] = '{32'h0000_300C, 0, 3, -1, 0, 32'h0000_3000, 32'h0000_300C, 14};
        vecs[3] = '{32'h0000_1010, 0, 1,  2, 0, 32'h0000_1010, 32'h0000_1010, 0};
        vecs[4] = '{32'h0000_1014, 0, 1,  2, 1, 32'h0000_1010, 32'h0000_1014, 0};
        vecs[5] = '{32'hFFFF_FFFF, 2, 1, -1, 0, 32'hFFFF_FFF0, 32'hFFFF_FFFC, 8};
        vecs[6] = '{32'h0000_4004, 0, 1, -1, 0, 32'h0000_4000, 32'h0000_4004, 6};

        idleInputs();
        reset_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset_state");
        reset_i = 1'b0;

        $display("[TB] table-driven fills");
        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        // Flush outranks a simultaneous miss in IDLE
        @(negedge clk);
        miss_i = 1'b1; miss_addr_i = 32'h0000_5000; repl_permit_i = 1'b1; flush_i = 1'b1;
        @(negedge clk);
        checkOutput("flush_vs_miss.busy",    32'(busy_o),    32'd0);
        checkOutput("flush_vs_miss.mem_req", 32'(mem_req_o), 32'd0);
        idleInputs();

        // Reset pulsed in the middle of REQ, then a clean fill
        $display("[TB] reset during REQ");
        @(negedge clk);
        miss_i = 1'b1; miss_addr_i = 32'h0000_6008; repl_permit_i = 1'b1;
        @(negedge clk);
        miss_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hDEAD_0001;
        @(negedge clk);
        checkOutput("pre_reset.mem_req", 32'(mem_req_o), 32'd1);
        mem_rdata_i = 32'hDEAD_0002; reset_i = 1'b1;
        @(negedge clk);
        checkAllZero("reset_mid_req");
        idleInputs();
        applyStimulus(vecs[6]);

        $display("[TB] randomized fills");
        for (int i = 0; i < 20; i++) begin
            rv.addr         = $urandom;
            rv.permitDelay  = int'($urandom_range(0, 3));
            rv.ackPeriod    = 0;
            rv.flushAfter   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, BLOCK_WORDS - 1)) : -1;
            rv.flushWithAck = 1'($urandom_range(0, 1));
            rv.expBase      = rv.addr & ~32'(4 * BLOCK_WORDS - 1);
            rv.expFirst     = rv.addr & ~32'd3;
            rv.expDone      = 0;
            applyStimulus(rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
